// File: rtl/pipeline_cpu_pkg.sv
// Shared encodings, ALU ops and pipeline-register layouts for the 5-stage MIPS-subset core.
package pipeline_cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  typedef struct packed {
    logic       reg_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic       branch;
    logic       use_imm;
    logic       reads_rt;
    alu_op_e    alu_op;
    logic [4:0] dst;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic        branch;
    logic        use_imm;
    alu_op_e     alu_op;
    logic [4:0]  dst;
    logic [31:0] pc4;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
  } id_ex_t;

  typedef struct packed {
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic [4:0]  dst;
    logic [31:0] res;
    logic [31:0] st_data;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_wr;
    logic [4:0]  dst;
    logic [31:0] wdata;
  } mem_wb_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Unrecognised encodings decode to all-zero control, i.e. a NOP.
  function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] funct,
                                   input logic [4:0] rt, input logic [4:0] rd);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.reg_wr   = 1'b1;
        c.reads_rt = 1'b1;
        c.dst      = rd;
        case (funct)
          FN_ADD:  c.alu_op = ALU_ADD;
          FN_SUB:  c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_SLT:  c.alu_op = ALU_SLT;
          default: c = '0;
        endcase
      end
      OP_ADDI: begin c.reg_wr = 1'b1; c.use_imm = 1'b1; c.dst = rt; end
      OP_SLTI: begin c.reg_wr = 1'b1; c.use_imm = 1'b1; c.dst = rt; c.alu_op = ALU_SLT; end
      OP_LW:   begin c.reg_wr = 1'b1; c.mem_rd = 1'b1; c.use_imm = 1'b1; c.dst = rt; end
      OP_SW:   begin c.mem_wr = 1'b1; c.use_imm = 1'b1; c.reads_rt = 1'b1; end
      OP_BEQ:  begin c.branch = 1'b1; c.reads_rt = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipeline_alu.sv
// Combinational ALU: add/sub/and/or and signed set-less-than.
module pipeline_alu
  import pipeline_cpu_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'd0, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/pipeline_cpu_dmem.sv
// Data memory: combinational read, synchronous write, cleared on reset.
module pipeline_cpu_dmem #(
  parameter  int DM_WORDS = 32,
  localparam int AW       = $clog2(DM_WORDS)
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic [AW-1:0] idx,
  output logic [31:0]   rdata,
  input  logic          we,
  input  logic [31:0]   wd
);
  logic [31:0] memory [DM_WORDS];

  assign rdata = memory[idx];

  always_ff @(posedge clk_i) begin
    if (rst_n) begin
      for (int i = 0; i < DM_WORDS; i++) memory[i] <= '0;
    end else if (we) begin
      memory[idx] <= wd;
    end
  end
endmodule

// File: rtl/pipeline_cpu_imem.sv
// Instruction memory: combinational read, contents survive reset.
module pipeline_cpu_imem #(
  parameter  int IM_WORDS = 32,
  localparam int AW       = $clog2(IM_WORDS)
) (
  input  logic          clk_i,
  input  logic [AW-1:0] idx,
  input  logic          we,
  input  logic [31:0]   wd,
  output logic [31:0]   instr
);
  logic [31:0] Instr_Mem [IM_WORDS];

  assign instr = Instr_Mem[idx];

  // Loader port; the core itself never writes program memory.
  always_ff @(posedge clk_i)
    if (we) Instr_Mem[idx] <= wd;
endmodule

// File: rtl/pipeline_cpu_rf.sv
// 32x32 register file, r0 hard zero, same-cycle write-to-read bypass.
module pipeline_cpu_rf (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] Reg_File [32];

  always_comb begin
    rd1 = Reg_File[ra1];
    rd2 = Reg_File[ra2];
    if (we && wa == ra1) rd1 = wd;
    if (we && wa == ra2) rd2 = wd;
    if (ra1 == 5'd0) rd1 = '0;
    if (ra2 == 5'd0) rd2 = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_n) begin
      for (int i = 0; i < 32; i++) Reg_File[i] <= '0;
    end else if (we && wa != 5'd0) begin
      Reg_File[wa] <= wd;
    end
  end
endmodule

// File: rtl/pipeline_cpu.sv
// Five-stage in-order MIPS-subset core: EX-resolved branches, full forwarding, load-use stall.
module pipeline_cpu
  import pipeline_cpu_pkg::*;
#(
  parameter int IM_WORDS = 32,
  parameter int DM_WORDS = 32
) (
  input logic clk_i,
  input logic rst_n
);
  localparam int IAW = $clog2(IM_WORDS);
  localparam int DAW = $clog2(DM_WORDS);

  logic [31:0] pc, pc4_f, instr_f;
  if_id_t  if_id;
  id_ex_t  id_ex;
  ex_mem_t ex_mem;
  mem_wb_t mem_wb;

  assign pc4_f = pc + 32'd4;

  pipeline_cpu_imem #(.IM_WORDS(IM_WORDS)) IM (
    .clk_i(clk_i), .idx(pc[IAW+1:2]), .we(1'b0), .wd(32'd0), .instr(instr_f)
  );

  logic [4:0]  rs_d, rt_d;
  logic [31:0] rs_val_d, rt_val_d, imm_d;
  ctrl_t       ctrl_d;
  logic        stall;

  assign rs_d   = if_id.instr[25:21];
  assign rt_d   = if_id.instr[20:16];
  assign imm_d  = sext16(if_id.instr[15:0]);
  assign ctrl_d = decode(if_id.instr[31:26], if_id.instr[5:0], rt_d, if_id.instr[15:11]);

  pipeline_cpu_rf RF (
    .clk_i(clk_i), .rst_n(rst_n),
    .ra1(rs_d), .ra2(rt_d), .rd1(rs_val_d), .rd2(rt_val_d),
    .we(mem_wb.reg_wr), .wa(mem_wb.dst), .wd(mem_wb.wdata)
  );

  assign stall = id_ex.mem_rd &&
                 ((id_ex.dst == rs_d) || (ctrl_d.reads_rt && id_ex.dst == rt_d));

  logic [31:0] fwd_a, fwd_b, alu_b, alu_y, br_target;
  logic        take;

  // Younger producer (EX/MEM) wins; r0 destinations never forward.
  function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] dflt);
    if (ex_mem.reg_wr && ex_mem.dst != 5'd0 && ex_mem.dst == src) return ex_mem.res;
    if (mem_wb.reg_wr && mem_wb.dst != 5'd0 && mem_wb.dst == src) return mem_wb.wdata;
    return dflt;
  endfunction

  always_comb begin
    fwd_a = fwd(id_ex.rs, id_ex.rs_val);
    fwd_b = fwd(id_ex.rt, id_ex.rt_val);
  end

  assign alu_b     = id_ex.use_imm ? id_ex.imm : fwd_b;
  assign take      = id_ex.branch && (fwd_a == fwd_b);
  assign br_target = id_ex.pc4 + (id_ex.imm << 2);

  pipeline_alu ALU (.op(id_ex.alu_op), .a(fwd_a), .b(alu_b), .y(alu_y));

  logic [31:0] dm_rdata, wb_data;

  pipeline_cpu_dmem #(.DM_WORDS(DM_WORDS)) DM (
    .clk_i(clk_i), .rst_n(rst_n), .idx(ex_mem.res[DAW+1:2]), .rdata(dm_rdata),
    .we(ex_mem.mem_wr), .wd(ex_mem.st_data)
  );

  assign wb_data = ex_mem.mem_rd ? dm_rdata : ex_mem.res;

  always_ff @(posedge clk_i) begin
    if (rst_n) begin
      pc     <= '0;
      if_id  <= '0;
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else begin
      // Flush outranks the load-use stall: the stalled instruction is on the wrong path.
      if (take) begin
        pc    <= br_target;
        if_id <= '0;
        id_ex <= '0;
      end else if (stall) begin
        id_ex <= '0;
      end else begin
        pc    <= pc4_f;
        if_id <= '{pc4: pc4_f, instr: instr_f};
        id_ex <= '{reg_wr: ctrl_d.reg_wr, mem_rd: ctrl_d.mem_rd, mem_wr: ctrl_d.mem_wr,
                   branch: ctrl_d.branch, use_imm: ctrl_d.use_imm, alu_op: ctrl_d.alu_op,
                   dst: ctrl_d.dst, pc4: if_id.pc4, rs_val: rs_val_d, rt_val: rt_val_d,
                   imm: imm_d, rs: rs_d, rt: rt_d};
      end
      ex_mem <= '{reg_wr: id_ex.reg_wr, mem_rd: id_ex.mem_rd, mem_wr: id_ex.mem_wr,
                  dst: id_ex.dst, res: alu_y, st_data: fwd_b};
      mem_wb <= '{reg_wr: ex_mem.reg_wr, dst: ex_mem.dst, wdata: wb_data};
    end
  end
endmodule

// File: tb/tb_pipeline_cpu.sv
// Scoreboard bench: expected RF/DM commits (value and edge) queued per program, monitor checks each commit.
module tb_pipeline_cpu;

  localparam logic [5:0] ADDI = 6'h08, SLTI = 6'h0A, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  pipeline_cpu #(.IM_WORDS(32), .DM_WORDS(32)) dut (.clk_i(clk), .rst_n(rst_n));

  always #5 clk = ~clk;

  typedef struct {
    bit          is_mem;
    int          idx;
    logic [31:0] val;
    int          edge_no;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] prog[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Edge 1 is the first fetch after reset is released.
  always @(posedge clk) cyc <= rst_n ? 0 : cyc + 1;

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rd, input int rs, input int rt);
    return {6'b0, 5'(rs), 5'(rt), 5'(rd), 5'b0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic push(input bit m, input int idx, input logic [31:0] v, input int e);
    exp_t x;
    x.is_mem = m; x.idx = idx; x.val = v; x.edge_no = e;
    exp_q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic commit(input bit m, input int idx, input logic [31:0] v);
    exp_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL commit_unexpected: %s[%0d]=0x%08h at edge %0d, expected no commit",
               m ? "mem" : "r", idx, v, cyc + 1);
    end else begin
      e = exp_q.pop_front();
      if (e.is_mem != m || e.idx != idx || e.val !== v || e.edge_no != cyc + 1) begin
        fails++;
        $display("FAIL commit: got %s[%0d]=0x%08h @edge %0d, expected %s[%0d]=0x%08h @edge %0d",
                 m ? "mem" : "r", idx, v, cyc + 1,
                 e.is_mem ? "mem" : "r", e.idx, e.val, e.edge_no);
      end
    end
  endtask

  // Pending writes are visible on the write ports half a cycle before they land.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (dut.RF.we && dut.RF.wa != 5'd0) commit(1'b0, int'(dut.RF.wa), dut.RF.wd);
      if (dut.DM.we) commit(1'b1, int'(dut.DM.idx), dut.DM.wd);
    end
  end

  task automatic check_reset(input string name);
    int nz;
    nz = 0;
    for (int i = 0; i < 32; i++) begin
      if (dut.RF.Reg_File[i] !== 32'd0) nz++;
      if (dut.DM.memory[i] !== 32'd0) nz++;
    end
    chk({name, "_nonzero_state"}, 32'(nz), 32'd0);
    chk({name, "_pc"}, dut.pc, 32'd0);
  endtask

  // Load the program with reset held, take one reset edge, then release.
  task automatic start_prog(input string name);
    for (int i = 0; i < 32; i++)
      dut.IM.Instr_Mem[i] = (i < prog.size()) ? prog[i] : 32'h0;
    @(posedge clk); #1;
    check_reset(name);
    rst_n = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic end_prog(input string name);
    chk({name, "_pending_commits"}, 32'(exp_q.size()), 32'd0);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  function automatic logic [31:0] rf(input int i);
    return dut.RF.Reg_File[i];
  endfunction

  task automatic push_mem_prog();
    push(0, 1, 32'd7, 5);
    push(1, 2, 32'd7, 5);
    push(0, 2, 32'd7, 7);
    push(0, 3, 32'd14, 9);   // one bubble: would be edge 8 without the stall
    push(0, 4, 32'd1, 10);
  endtask

  initial begin
    // ALU chain, every operand forwarded or bypassed, one instruction per cycle.
    prog = '{enc_i(ADDI, 1, 0, 5), enc_i(ADDI, 2, 1, 3),
             enc_r(F_ADD, 3, 1, 2), enc_r(F_SUB, 4, 3, 1)};
    push(0, 1, 32'd5, 5); push(0, 2, 32'd8, 6);
    push(0, 3, 32'd13, 7); push(0, 4, 32'd8, 8);
    start_prog("alu_chain");
    run(16);
    chk("alu_chain_r1", rf(1), 32'd5);  chk("alu_chain_r2", rf(2), 32'd8);
    chk("alu_chain_r3", rf(3), 32'd13); chk("alu_chain_r4", rf(4), 32'd8);
    end_prog("alu_chain");

    // Logic ops and signed compares.
    prog = '{enc_i(ADDI, 1, 0, 12), enc_i(ADDI, 2, 0, 10),
             enc_r(F_AND, 3, 1, 2), enc_r(F_OR, 4, 1, 2),
             enc_r(F_SLT, 5, 2, 1), enc_i(SLTI, 6, 1, -1),
             enc_i(ADDI, 9, 0, -3), enc_r(F_SLT, 8, 9, 1)};
    push(0, 1, 32'd12, 5); push(0, 2, 32'd10, 6);
    push(0, 3, 32'd8, 7);  push(0, 4, 32'd14, 8);
    push(0, 5, 32'd1, 9);  push(0, 6, 32'd0, 10);
    push(0, 9, 32'hFFFF_FFFD, 11); push(0, 8, 32'd1, 12);
    start_prog("logic");
    run(16);
    chk("logic_and", rf(3), 32'd8);  chk("logic_or", rf(4), 32'd14);
    chk("logic_slt", rf(5), 32'd1);  chk("logic_slti_neg", rf(6), 32'd0);
    chk("logic_slt_signed", rf(8), 32'd1);
    end_prog("logic");

    // Store, load, dependent use (load-use stall).
    prog = '{enc_i(ADDI, 1, 0, 7), enc_i(SW, 1, 0, 8), enc_i(LW, 2, 0, 8),
             enc_r(F_ADD, 3, 2, 2), enc_i(ADDI, 4, 0, 1)};
    push_mem_prog();
    start_prog("mem");
    run(16);
    chk("mem_word2", dut.DM.memory[2], 32'd7);
    chk("mem_r2", rf(2), 32'd7); chk("mem_r3", rf(3), 32'd14); chk("mem_r4", rf(4), 32'd1);
    end_prog("mem");

    // Taken branch flushes the two following instructions.
    prog = '{enc_i(ADDI, 1, 0, 1), enc_i(BEQ, 0, 0, 2),
             enc_i(ADDI, 7, 0, 1), enc_i(ADDI, 7, 0, 2),
             enc_i(ADDI, 8, 0, 3), enc_i(ADDI, 9, 8, 1)};
    push(0, 1, 32'd1, 5); push(0, 8, 32'd3, 9); push(0, 9, 32'd4, 10);
    start_prog("br_taken");
    run(16);
    chk("br_taken_r7", rf(7), 32'd0); chk("br_taken_r8", rf(8), 32'd3);
    chk("br_taken_r9", rf(9), 32'd4);
    end_prog("br_taken");

    // Not-taken branch on a forwarded operand; r0 write discarded and never forwarded.
    prog = '{enc_i(ADDI, 1, 0, 4), enc_i(BEQ, 0, 1, 2), enc_i(ADDI, 2, 0, 6),
             enc_i(ADDI, 0, 0, 9), enc_r(F_ADD, 3, 0, 2)};
    push(0, 1, 32'd4, 5); push(0, 2, 32'd6, 7); push(0, 3, 32'd6, 9);
    start_prog("br_not");
    run(16);
    chk("br_not_r2", rf(2), 32'd6); chk("r0_zero", rf(0), 32'd0);
    chk("r0_no_fwd_r3", rf(3), 32'd6);
    end_prog("br_not");

    // Mid-run reset, then identical re-execution.
    prog = '{enc_i(ADDI, 1, 0, 7), enc_i(SW, 1, 0, 8), enc_i(LW, 2, 0, 8),
             enc_r(F_ADD, 3, 2, 2), enc_i(ADDI, 4, 0, 1)};
    push_mem_prog();
    start_prog("midrst_a");
    run(6);
    chk("midrst_pre_r1", rf(1), 32'd7);
    chk("midrst_pre_mem2", dut.DM.memory[2], 32'd7);
    rst_n = 1'b1;
    exp_q.delete();
    push_mem_prog();
    start_prog("midrst_b");
    run(30);
    chk("midrst_r1", rf(1), 32'd7);  chk("midrst_r2", rf(2), 32'd7);
    chk("midrst_r3", rf(3), 32'd14); chk("midrst_r4", rf(4), 32'd1);
    chk("midrst_mem2", dut.DM.memory[2], 32'd7);
    end_prog("midrst_b");

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_cpu.md
# pipeline_cpu

Five-stage in-order 32-bit MIPS-subset processor (IF, ID, EX, MEM, WB) with internal instruction memory, register file and data memory. It is the top of the CPU design. Benches preload program memory and inspect architectural state hierarchically: instances IM (array Instr_Mem), RF (array Reg_File) and DM (array memory).

## Interface
- IM_WORDS, 32: instruction memory depth in 32-bit words.
- DM_WORDS, 32: data memory depth in 32-bit words.
- clk_i  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous and active-high (asserted when 1, despite the name).
- No other ports. Results are visible only through RF.Reg_File[0..31] and DM.memory[0..DM_WORDS-1], each 32-bit.

## Operation
- Instructions:
  - R-type (op 000000), funct: add 100000, sub 100010, and 100100, or 100101, slt 101010 (signed).
  - I-type, sign-extended imm16: addi 001000, slti 001010, lw 100011, sw 101011, beq 000100.
  - Any other encoding, including 0x00000000, is a NOP: no register or memory write.
- Writes to r0 are discarded. r0 always reads 0.
- Addressing:
  - PC is byte-addressed, +4 per fetch. IM index = PC[log2(IM_WORDS)+1:2].
  - Data address = rs + sext(imm). DM index = addr[log2(DM_WORDS)+1:2]. Indices wrap modulo depth.
- Branch: target = PC+4 + (sext(imm)<<2). Resolved in EX.
  - Taken: PC loads target; IF/ID and ID/EX are flushed to NOP (2-cycle penalty).
  - Not taken: no penalty (predict not-taken).
- Forwarding into EX operands (rs, rt, including sw store data):
  - EX/MEM result has priority over MEM/WB write data.
  - Never forward when the destination is r0.
- Load-use hazard: lw in EX whose rt equals the ID instruction's rs or rt (rt only if that instruction reads rt).
  - PC and IF/ID hold for one cycle; a NOP bubble goes into ID/EX.
- A taken branch and a load-use stall in the same cycle: the flush wins.
- Register file writes in WB. A same-cycle read of the register being written returns the new value (write-then-read bypass).

## Timing
- Reset (rst_n=1 at a clock edge):
  - PC=0.
  - All pipeline registers cleared to NOP (no writes).
  - Reg_File all 0. DM.memory all 0.
  - Instr_Mem is NOT reset; its contents persist.
- First fetch happens on the first edge after rst_n is deasserted. Reset mid-run aborts all in-flight instructions.
- Latency: an instruction fetched on edge n writes the register file on edge n+4 and commits sw to memory on edge n+3.
- Steady state is one instruction per cycle, excluding stalls and flushes.
- DM read is combinational within MEM; DM write is synchronous.
- IM read is combinational.
- PC past IM_WORDS wraps through the index truncation. Empty memory executes NOPs indefinitely.

## Structure
- Shared package pipeline_cpu_pkg: opcode/funct constants, ALU-operation enum, NOP encoding, pipeline-register structs (if_id, id_ex, ex_mem, mem_wb).
- Required sub-module instances with fixed instance names:
  - IM (instruction memory, Instr_Mem).
  - RF (register file, Reg_File).
  - DM (data memory, memory).
- The ALU, forwarding unit and hazard unit are natural sub-modules. The ALU is the most self-contained; name it pipeline_alu.

## Test plan
- Reset then ALU chain with forwarding:
  - addi r1,r0,5; addi r2,r1,3; add r3,r1,r2; sub r4,r3,r1.
  - Expect r1=5, r2=8, r3=13, r4=8, without inserted NOPs.
- Logic and compare:
  - r1=12, r2=10; and, or, slt r5,r2,r1; slti r6,r1,-1.
  - Expect 8, 14, r5=1, r6=0.
- Memory with load-use stall:
  - addi r1,r0,7; sw r1,8(r0); lw r2,8(r0); add r3,r2,r2.
  - Expect memory[2]=7, r2=7, r3=14, and exactly one bubble.
- Branch taken:
  - beq r0,r0,+2 followed by two addi r7 instructions.
  - Expect r7 unchanged (0), both flushed, and the target executes.
- Branch not taken, plus r0:
  - beq r1,r0 with r1≠0: next instruction executes.
  - addi r0,r0,9: r0 stays 0.
- Mid-run reset:
  - Assert rst_n for one edge during execution.
  - Expect all registers and memory 0, then re-execution from PC=0 reproducing identical final state after 30 cycles.
